// File: rtl/reg_issue_stage.sv
// Register-read / issue stage: 32x32 regfile with write-first ports, load-use scoreboard,
// late-forward capture during EX hold. Optional difftest ports under REG_ISSUE_DIFFTEST_EN.
module reg_issue_stage #(
   parameter int unsigned LANES     = 2,
   parameter int unsigned NWPORT    = 3,
   parameter int unsigned LOAD_LAT  = 2,
   parameter int unsigned PAYLOAD_W = 160
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         mem_adv,
   input  logic [NWPORT-1:0]            wb_we,
   input  logic [NWPORT*5-1:0]          wb_addr,
   input  logic [NWPORT*32-1:0]         wb_data,
   input  logic                         reg_readygo,
   output logic                         reg_allowin,
   input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
   input  logic [LANES*5-1:0]           in_rj,
   input  logic [LANES*5-1:0]           in_rk,
   input  logic [LANES*5-1:0]           in_rd,
   input  logic                         in_is_load,
   input  logic                         ex_allowin,
   output logic                         ex_readygo,
   output logic                         ex_valid,
   output logic [LANES*PAYLOAD_W-1:0]   ex_payload,
   output logic [LANES*32-1:0]          ex_rj_data,
   output logic [LANES*32-1:0]          ex_rk_data,
   output logic [LANES*5-1:0]           ex_rj,
   output logic [LANES*5-1:0]           ex_rk,
   output logic [LANES*5-1:0]           ex_rd,
   output logic                         ex_is_load,
   input  logic                         fwd_hold,
   input  logic [LANES-1:0]             fwd_valid_j,
   input  logic [LANES-1:0]             fwd_valid_k,
   input  logic [LANES*32-1:0]          fwd_data_j,
   input  logic [LANES*32-1:0]          fwd_data_k
`ifdef REG_ISSUE_DIFFTEST_EN
   ,
   input  logic [63:0]                  stable_counter,
   output logic [1023:0]                diff_regs,
   output logic [63:0]                  stable_counter_diff
`endif
);

   logic [31:0]                r_rf [32];
   logic [4:0]                 r_sb [LOAD_LAT];

   logic                       r_ex_valid;
   logic                       r_ex_is_load;
   logic [LANES*PAYLOAD_W-1:0] r_ex_payload;
   logic [LANES*32-1:0]        r_rj_data;
   logic [LANES*32-1:0]        r_rk_data;
   logic [LANES*5-1:0]         r_ex_rj;
   logic [LANES*5-1:0]         r_ex_rk;
   logic [LANES*5-1:0]         r_ex_rd;
   logic [LANES-1:0]           r_sticky_j;
   logic [LANES-1:0]           r_sticky_k;

   logic [LANES*32-1:0]        w_rj_rd;
   logic [LANES*32-1:0]        w_rk_rd;
   logic                       w_hazard;
   logic                       w_stall;
   logic                       w_load;
   logic                       w_clear;

   // Regfile array; later port index overrides earlier on a same-address write.
   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < NWPORT; p++) begin
         if (wb_we[p] && (wb_addr[p*5 +: 5] != 5'd0)) begin
            r_rf[wb_addr[p*5 +: 5]] <= wb_data[p*32 +: 32];
         end
      end
   end

   // Write-first read ports.
   always_comb begin
      w_rj_rd = '0;
      w_rk_rd = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         w_rj_rd[l*32 +: 32] = r_rf[in_rj[l*5 +: 5]];
         w_rk_rd[l*32 +: 32] = r_rf[in_rk[l*5 +: 5]];
         for (int unsigned p = 0; p < NWPORT; p++) begin
            if (wb_we[p] && (wb_addr[p*5 +: 5] == in_rj[l*5 +: 5])) begin
               w_rj_rd[l*32 +: 32] = wb_data[p*32 +: 32];
            end
            if (wb_we[p] && (wb_addr[p*5 +: 5] == in_rk[l*5 +: 5])) begin
               w_rk_rd[l*32 +: 32] = wb_data[p*32 +: 32];
            end
         end
         if (in_rj[l*5 +: 5] == 5'd0) begin
            w_rj_rd[l*32 +: 32] = '0;
         end
         if (in_rk[l*5 +: 5] == 5'd0) begin
            w_rk_rd[l*32 +: 32] = '0;
         end
      end
   end

   // Load-use hazard against pending loads and the load currently in EX.
   always_comb begin
      logic [4:0] w_src;
      w_hazard = 1'b0;
      w_src    = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         for (int unsigned s = 0; s < 2; s++) begin
            w_src = (s == 0) ? in_rj[l*5 +: 5] : in_rk[l*5 +: 5];
            if (w_src != 5'd0) begin
               for (int unsigned i = 0; i < LOAD_LAT; i++) begin
                  if (r_sb[i] == w_src) begin
                     w_hazard = 1'b1;
                  end
               end
               if (r_ex_valid && r_ex_is_load && (r_ex_rd[4:0] == w_src)) begin
                  w_hazard = 1'b1;
               end
            end
         end
      end
   end

   assign w_stall     = reg_readygo & w_hazard;
   assign w_load      = reg_readygo & ex_allowin & ~w_hazard;
   // A bubble clears exactly the same state as reset/flush, so the two share one branch.
   assign w_clear     = reset | flush | (ex_allowin & ~w_load);
   assign ex_readygo  = ~w_stall;
   assign reg_allowin = ex_allowin & ~w_stall;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            r_sb[i] <= '0;
         end
      end else if (mem_adv) begin
         r_sb[0] <= (r_ex_valid && r_ex_is_load) ? r_ex_rd[4:0] : 5'd0;
         for (int unsigned i = 1; i < LOAD_LAT; i++) begin
            r_sb[i] <= r_sb[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush || !fwd_hold) begin
         r_sticky_j <= '0;
         r_sticky_k <= '0;
      end else begin
         r_sticky_j <= r_sticky_j | fwd_valid_j;
         r_sticky_k <= r_sticky_k | fwd_valid_k;
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_ex_valid   <= 1'b0;
         r_ex_is_load <= 1'b0;
         r_ex_payload <= '0;
         r_rj_data    <= '0;
         r_rk_data    <= '0;
         r_ex_rj      <= '0;
         r_ex_rk      <= '0;
         r_ex_rd      <= '0;
      end else if (w_load) begin
         r_ex_valid   <= 1'b1;
         r_ex_is_load <= in_is_load;
         r_ex_payload <= in_payload;
         r_rj_data    <= w_rj_rd;
         r_rk_data    <= w_rk_rd;
         r_ex_rj      <= in_rj;
         r_ex_rk      <= in_rk;
         r_ex_rd      <= in_rd;
      end else if (fwd_hold) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            if (fwd_valid_j[l] || r_sticky_j[l]) begin
               r_rj_data[l*32 +: 32] <= fwd_data_j[l*32 +: 32];
            end
            if (fwd_valid_k[l] || r_sticky_k[l]) begin
               r_rk_data[l*32 +: 32] <= fwd_data_k[l*32 +: 32];
            end
         end
      end
   end

   assign ex_valid   = r_ex_valid;
   assign ex_is_load = r_ex_is_load;
   assign ex_payload = r_ex_payload;
   assign ex_rj_data = r_rj_data;
   assign ex_rk_data = r_rk_data;
   assign ex_rj      = r_ex_rj;
   assign ex_rk      = r_ex_rk;
   assign ex_rd      = r_ex_rd;

`ifdef REG_ISSUE_DIFFTEST_EN
   logic [63:0] r_stable_counter;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stable_counter <= '0;
      end else begin
         r_stable_counter <= stable_counter;
      end
   end

   always_comb begin
      diff_regs = '0;
      for (int unsigned i = 1; i < 32; i++) begin
         diff_regs[i*32 +: 32] = r_rf[i];
      end
   end

   assign stable_counter_diff = r_stable_counter;
`endif

endmodule

// File: tb/tb_reg_issue_stage.sv
// Directed bench for reg_issue_stage with default parameters (2 lanes, 3 write ports, LOAD_LAT 2).
module tb_reg_issue_stage;

   localparam int unsigned LANES     = 2;
   localparam int unsigned NWPORT    = 3;
   localparam int unsigned LOAD_LAT  = 2;
   localparam int unsigned PAYLOAD_W = 160;

   logic                         clk;
   logic                         reset;
   logic                         flush;
   logic                         mem_adv;
   logic [NWPORT-1:0]            wb_we;
   logic [NWPORT*5-1:0]          wb_addr;
   logic [NWPORT*32-1:0]         wb_data;
   logic                         reg_readygo;
   logic                         reg_allowin;
   logic [LANES*PAYLOAD_W-1:0]   in_payload;
   logic [LANES*5-1:0]           in_rj, in_rk, in_rd;
   logic                         in_is_load;
   logic                         ex_allowin;
   logic                         ex_readygo;
   logic                         ex_valid;
   logic [LANES*PAYLOAD_W-1:0]   ex_payload;
   logic [LANES*32-1:0]          ex_rj_data, ex_rk_data;
   logic [LANES*5-1:0]           ex_rj, ex_rk, ex_rd;
   logic                         ex_is_load;
   logic                         fwd_hold;
   logic [LANES-1:0]             fwd_valid_j, fwd_valid_k;
   logic [LANES*32-1:0]          fwd_data_j, fwd_data_k;

   int checks = 0;
   int errors = 0;

   reg_issue_stage #(
      .LANES     (LANES),
      .NWPORT    (NWPORT),
      .LOAD_LAT  (LOAD_LAT),
      .PAYLOAD_W (PAYLOAD_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .mem_adv     (mem_adv),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .reg_readygo (reg_readygo),
      .reg_allowin (reg_allowin),
      .in_payload  (in_payload),
      .in_rj       (in_rj),
      .in_rk       (in_rk),
      .in_rd       (in_rd),
      .in_is_load  (in_is_load),
      .ex_allowin  (ex_allowin),
      .ex_readygo  (ex_readygo),
      .ex_valid    (ex_valid),
      .ex_payload  (ex_payload),
      .ex_rj_data  (ex_rj_data),
      .ex_rk_data  (ex_rk_data),
      .ex_rj       (ex_rj),
      .ex_rk       (ex_rk),
      .ex_rd       (ex_rd),
      .ex_is_load  (ex_is_load),
      .fwd_hold    (fwd_hold),
      .fwd_valid_j (fwd_valid_j),
      .fwd_valid_k (fwd_valid_k),
      .fwd_data_j  (fwd_data_j),
      .fwd_data_k  (fwd_data_k)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush       = 1'b0;
      mem_adv     = 1'b0;
      wb_we       = '0;
      wb_addr     = '0;
      wb_data     = '0;
      reg_readygo = 1'b0;
      in_payload  = '0;
      in_rj       = '0;
      in_rk       = '0;
      in_rd       = '0;
      in_is_load  = 1'b0;
      ex_allowin  = 1'b1;
      fwd_hold    = 1'b0;
      fwd_valid_j = '0;
      fwd_valid_k = '0;
      fwd_data_j  = '0;
      fwd_data_k  = '0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({ex_valid, ex_is_load, ex_rj, ex_rk, ex_rd} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got v=%0b l=%0b rj=%0h rk=%0h rd=%0h, expected all 0",
                  ex_valid, ex_is_load, ex_rj, ex_rk, ex_rd);
      end
      checks++;
      if ({ex_payload, ex_rj_data, ex_rk_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: got rj_data=%0h rk_data=%0h, expected 0", ex_rj_data, ex_rk_data);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({ex_readygo, reg_allowin} !== 2'b11) begin
         errors++;
         $display("FAIL reset_handshake: got readygo=%0b allowin=%0b, expected 1 1", ex_readygo, reg_allowin);
      end
   endtask

   task automatic test_bypass();
      logic [LANES*PAYLOAD_W-1:0] pl;
      pl = {160'h2222_0000_0000_0000_0000_0000_0000_0000_0000_BBBB, 160'h1111_0000_0000_0000_0000_0000_0000_0000_0000_AAAA};
      idle();
      reg_readygo = 1'b1;
      in_payload  = pl;
      in_rj       = {5'd5, 5'd0};
      in_rd       = {5'd6, 5'd1};
      wb_we       = 3'b001;
      wb_addr     = {5'd0, 5'd0, 5'd5};
      wb_data     = {32'h0, 32'h0, 32'h0000_1234};
      tick();
      checks++;
      if (ex_rj_data[63:32] !== 32'h0000_1234) begin
         errors++;
         $display("FAIL bypass_lane1: got %0h expected 1234", ex_rj_data[63:32]);
      end
      checks++;
      if ({ex_valid, ex_payload, ex_rd} !== {1'b1, pl, 5'd6, 5'd1}) begin
         errors++;
         $display("FAIL accept_fields: got v=%0b rd=%0h expected v=1 rd=c1", ex_valid, ex_rd);
      end
      // ports 0 and 2 both write x7; port 2 must win on the bypass path
      wb_we   = 3'b101;
      wb_addr = {5'd7, 5'd0, 5'd7};
      wb_data = {32'h0000_000B, 32'h0, 32'h0000_000A};
      in_rj   = {5'd0, 5'd5};
      in_rk   = {5'd0, 5'd7};
      tick();
      checks++;
      if (ex_rk_data[31:0] !== 32'h0000_000B) begin
         errors++;
         $display("FAIL bypass_collision: got %0h expected b", ex_rk_data[31:0]);
      end
      checks++;
      if (ex_rj_data[31:0] !== 32'h0000_1234) begin
         errors++;
         $display("FAIL array_read_x5: got %0h expected 1234", ex_rj_data[31:0]);
      end
      wb_we   = 3'b010;
      wb_addr = '0;
      wb_data = {32'h0, 32'h0000_FFFF, 32'h0};
      in_rj   = {5'd7, 5'd0};
      in_rk   = '0;
      tick();
      checks++;
      if (ex_rj_data !== {32'h0000_000B, 32'h0}) begin
         errors++;
         $display("FAIL array_collision_r0: got %0h expected b_00000000", ex_rj_data);
      end
      wb_we       = '0;
      reg_readygo = 1'b0;
      tick();
      checks++;
      if ({ex_valid, ex_payload, ex_rj_data} !== '0) begin
         errors++;
         $display("FAIL bubble: got v=%0b rj_data=%0h expected 0", ex_valid, ex_rj_data);
      end
   endtask

   task automatic test_load_use();
      idle();
      reg_readygo = 1'b1;
      in_is_load  = 1'b1;
      in_rd       = {5'd0, 5'd9};
      tick();
      checks++;
      if ({ex_valid, ex_is_load, ex_rd[4:0]} !== {1'b1, 1'b1, 5'd9}) begin
         errors++;
         $display("FAIL load_accept: got v=%0b l=%0b rd=%0d expected 1 1 9", ex_valid, ex_is_load, ex_rd[4:0]);
      end
      in_is_load = 1'b0;
      in_rd      = {5'd0, 5'd10};
      in_rk      = {5'd0, 5'd9};
      mem_adv    = 1'b1;
      #1;
      checks++;
      if ({ex_readygo, reg_allowin} !== 2'b00) begin
         errors++;
         $display("FAIL load_use_stall: got readygo=%0b allowin=%0b expected 0 0", ex_readygo, reg_allowin);
      end
      tick();
      mem_adv = 1'b0;
      checks++;
      if ({ex_valid, ex_rd} !== '0) begin
         errors++;
         $display("FAIL load_use_bubble: got v=%0b rd=%0h expected 0 0", ex_valid, ex_rd);
      end
      repeat (3) tick();
      checks++;
      if ({ex_readygo, ex_valid} !== 2'b00) begin
         errors++;
         $display("FAIL stall_no_memadv: got readygo=%0b v=%0b expected 0 0", ex_readygo, ex_valid);
      end
      mem_adv = 1'b1;
      tick();
      checks++;
      if (ex_readygo !== 1'b0) begin
         errors++;
         $display("FAIL stall_sb1: got readygo=%0b expected 0", ex_readygo);
      end
      tick();
      mem_adv = 1'b0;
      #1;
      checks++;
      if ({ex_readygo, reg_allowin} !== 2'b11) begin
         errors++;
         $display("FAIL sb_drained: got readygo=%0b allowin=%0b expected 1 1", ex_readygo, reg_allowin);
      end
      tick();
      checks++;
      if ({ex_valid, ex_rk[4:0]} !== {1'b1, 5'd9}) begin
         errors++;
         $display("FAIL dependent_accept: got v=%0b rk=%0d expected 1 9", ex_valid, ex_rk[4:0]);
      end
   endtask

   task automatic test_zero_src();
      idle();
      reg_readygo = 1'b1;
      in_is_load  = 1'b1;
      in_rd       = '0;
      tick();
      in_is_load = 1'b0;
      in_rd      = {5'd0, 5'd2};
      mem_adv    = 1'b1;
      #1;
      checks++;
      if (ex_readygo !== 1'b1) begin
         errors++;
         $display("FAIL zero_src_nostall: got readygo=%0b expected 1", ex_readygo);
      end
      tick();
      mem_adv = 1'b0;
      checks++;
      if ({ex_valid, ex_rj_data[31:0], ex_rd[4:0]} !== {1'b1, 32'h0, 5'd2}) begin
         errors++;
         $display("FAIL zero_src_accept: got v=%0b rj0=%0h rd0=%0d expected 1 0 2", ex_valid, ex_rj_data[31:0], ex_rd[4:0]);
      end
   endtask

   task automatic test_fwd_hold();
      idle();
      reg_readygo = 1'b1;
      in_rj       = {5'd0, 5'd5};
      tick();
      checks++;
      if (ex_rj_data[31:0] !== 32'h0000_1234) begin
         errors++;
         $display("FAIL fwd_setup: got %0h expected 1234", ex_rj_data[31:0]);
      end
      ex_allowin  = 1'b0;
      fwd_hold    = 1'b1;
      in_rj       = {5'd0, 5'd7};
      fwd_valid_j = 2'b01;
      fwd_data_j  = {32'h0, 32'h0000_DEAD};
      fwd_data_k  = {32'h0, 32'h0000_7777};
      #1;
      checks++;
      if (reg_allowin !== 1'b0) begin
         errors++;
         $display("FAIL hold_allowin: got %0b expected 0", reg_allowin);
      end
      tick();
      checks++;
      if ({ex_rj_data[31:0], ex_rk_data[31:0]} !== {32'h0000_DEAD, 32'h0}) begin
         errors++;
         $display("FAIL fwd_strobe: got rj0=%0h rk0=%0h expected dead 0", ex_rj_data[31:0], ex_rk_data[31:0]);
      end
      fwd_valid_j = '0;
      tick();
      fwd_data_j = {32'h0, 32'h0000_BEEF};
      tick();
      checks++;
      if ({ex_valid, ex_rj[4:0], ex_rj_data[31:0], ex_rk_data[31:0]} !== {1'b1, 5'd5, 32'h0000_BEEF, 32'h0}) begin
         errors++;
         $display("FAIL fwd_sticky: got v=%0b rj=%0d rj0=%0h rk0=%0h expected 1 5 beef 0",
                  ex_valid, ex_rj[4:0], ex_rj_data[31:0], ex_rk_data[31:0]);
      end
      fwd_hold   = 1'b0;
      fwd_data_j = {32'h0, 32'h0000_1111};
      tick();
      checks++;
      if (ex_rj_data[31:0] !== 32'h0000_BEEF) begin
         errors++;
         $display("FAIL fwd_release_hold: got %0h expected beef", ex_rj_data[31:0]);
      end
      fwd_hold   = 1'b1;
      fwd_data_j = {32'h0, 32'h0000_2222};
      tick();
      checks++;
      if (ex_rj_data[31:0] !== 32'h0000_BEEF) begin
         errors++;
         $display("FAIL sticky_cleared: got %0h expected beef", ex_rj_data[31:0]);
      end
   endtask

   task automatic test_flush();
      idle();
      reg_readygo = 1'b1;
      in_is_load  = 1'b1;
      in_rd       = {5'd0, 5'd12};
      tick();
      flush      = 1'b1;
      mem_adv    = 1'b1;
      in_is_load = 1'b0;
      in_rj      = {5'd0, 5'd12};
      in_rd      = '0;
      tick();
      checks++;
      if ({ex_valid, ex_is_load, ex_rd, ex_rj, ex_rj_data} !== '0) begin
         errors++;
         $display("FAIL flush_clear: got v=%0b l=%0b rd=%0h rj=%0h expected all 0", ex_valid, ex_is_load, ex_rd, ex_rj);
      end
      flush   = 1'b0;
      mem_adv = 1'b0;
      #1;
      checks++;
      if (ex_readygo !== 1'b1) begin
         errors++;
         $display("FAIL flush_sb_clear: got readygo=%0b expected 1", ex_readygo);
      end
      tick();
      checks++;
      if ({ex_valid, ex_rj[4:0]} !== {1'b1, 5'd12}) begin
         errors++;
         $display("FAIL flush_next_accept: got v=%0b rj0=%0d expected 1 12", ex_valid, ex_rj[4:0]);
      end
   endtask

   task automatic test_reset_mid_hold();
      idle();
      reg_readygo = 1'b1;
      in_is_load  = 1'b1;
      in_rd       = {5'd0, 5'd3};
      tick();
      in_rd   = {5'd0, 5'd4};
      mem_adv = 1'b1;
      tick();
      ex_allowin  = 1'b0;
      reg_readygo = 1'b0;
      tick();
      mem_adv     = 1'b0;
      fwd_hold    = 1'b1;
      reg_readygo = 1'b1;
      in_is_load  = 1'b0;
      in_rd       = '0;
      in_rj       = {5'd3, 5'd0};
      #1;
      checks++;
      if (ex_readygo !== 1'b0) begin
         errors++;
         $display("FAIL sb_full_lane1_stall: got readygo=%0b expected 0", ex_readygo);
      end
      tick();
      checks++;
      if ({ex_valid, ex_is_load, ex_rd[4:0]} !== {1'b1, 1'b1, 5'd4}) begin
         errors++;
         $display("FAIL mid_hold_state: got v=%0b l=%0b rd0=%0d expected 1 1 4", ex_valid, ex_is_load, ex_rd[4:0]);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({ex_valid, ex_is_load, ex_rd, ex_payload, ex_rj_data, ex_rk_data} !== '0) begin
         errors++;
         $display("FAIL reset_mid_hold: got v=%0b l=%0b rd=%0h expected all 0", ex_valid, ex_is_load, ex_rd);
      end
      checks++;
      if ({ex_readygo, reg_allowin} !== 2'b10) begin
         errors++;
         $display("FAIL reset_allowin_low: got readygo=%0b allowin=%0b expected 1 0", ex_readygo, reg_allowin);
      end
      ex_allowin = 1'b1;
      #1;
      checks++;
      if (reg_allowin !== 1'b1) begin
         errors++;
         $display("FAIL reset_allowin_high: got %0b expected 1", reg_allowin);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_bypass();
      test_load_use();
      test_zero_src();
      test_fwd_hold();
      test_flush();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_issue_stage.md
Name: reg_issue_stage

Overview:
- Parametrised successor of the single-pair ID/register-read-to-EX pipeline register.
- Holds the architectural 32x32 register file with NWPORT write-first write ports, and reads two sources per lane for LANES lanes.
- Tracks in-flight loads in a LOAD_LAT-deep scoreboard and stalls on load-use hazards.
- Captures late forwarded operands while EX is held, then presents a registered bundle to EX1.

Parameters:
- LANES, 2, issue lanes (1..4).
- NWPORT, 3, regfile write ports (1..4); a higher port index wins on a same-address write.
- LOAD_LAT, 2, pending-load scoreboard depth in mem_adv steps (1..4).
- PAYLOAD_W, 160, opaque per-lane sideband width (pc, inst, uop, imm, exception bits).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  kill stage contents and scoreboard.
- mem_adv  in  1  memory pipe advanced (dcache_rready); shifts the scoreboard.
- wb_we  in  NWPORT  write enables.
- wb_addr  in  NWPORT*5  write addresses.
- wb_data  in  NWPORT*32  write data.
- reg_readygo  in  1  upstream bundle valid.
- reg_allowin  out  1  stage accepts the upstream bundle.
- in_payload  in  LANES*PAYLOAD_W  sideband.
- in_rj, in_rk, in_rd  in  LANES*5 each  source and destination addresses.
- in_is_load  in  1  lane-0 instruction is a load; only lane 0 issues loads.
- ex_allowin  in  1  EX can accept.
- ex_readygo  out  1  stage has no hazard.
- ex_valid  out  1  registered bundle valid.
- ex_payload  out  LANES*PAYLOAD_W  registered sideband.
- ex_rj_data, ex_rk_data  out  LANES*32 each  operands.
- ex_rj, ex_rk, ex_rd  out  LANES*5 each  registered addresses.
- ex_is_load  out  1  registered lane-0 load flag.
- fwd_hold  in  1  downstream hold active (stall_D).
- fwd_valid_j, fwd_valid_k  in  LANES each  forward strobes.
- fwd_data_j, fwd_data_k  in  LANES*32 each  forwarded values.

Behaviour:
- Reset: every output register is 0, the scoreboard is 0 and the sticky flags are 0. The reset is synchronous and active-high on clk.
- Regfile: r0 reads 0 and ignores writes. Reads are combinational with write-first bypass: a same-cycle write to the read address returns wb_data, taking the highest enabled port index on a collision. The array update also uses the highest index on a collision.
- Scoreboard: sb[0..LOAD_LAT-1], 5 bits per entry.
  - On mem_adv, sb[0] takes (ex_valid & ex_is_load) ? ex_rd[lane0] : 0, and sb[i] takes sb[i-1].
  - On flush or reset, all entries clear to 0. Flush wins over mem_adv.
- stall: asserted when any incoming rj/rk of any lane equals a nonzero sb entry, or equals the nonzero ex_rd[lane0] while ex_valid & ex_is_load. Address 0 never stalls. stall is qualified by reg_readygo.
- ex_readygo = ~stall.
- reg_allowin = ex_allowin & ~stall.
- Register update priority, applied per clk:
  1. reset or flush: clear all outputs.
  2. reg_readygo & ex_allowin & ~stall: load inputs and regfile reads, set ex_valid=1. Latency is one cycle.
  3. ex_allowin & (~reg_readygo | stall): insert a bubble; ex_valid=0 and all other outputs are 0.
  4. Otherwise hold. During hold with fwd_hold, each operand X takes fwd_data_X when (fwd_valid_X | sticky_X).
- sticky_X: set when fwd_hold & fwd_valid_X; cleared when ~fwd_hold, on reset, or on flush. This keeps the youngest forwarded value across multi-cycle holds.
- Simultaneous load into the stage and a writeback to the same source register: the bypassed write data is captured.

Optional Feature:
- Macro REG_ISSUE_DIFFTEST_EN.
- When defined, adds an output port diff_regs (out, 1024 bits): a flat snapshot of r0..r31 after the array update (r0 at [31:0]), plus a registered 64-bit stable_counter passthrough (input stable_counter, output stable_counter_diff, one-cycle delay, reset 0).
- When undefined, these ports do not exist and no snapshot logic is built.

Test Plan:
- Write x5=0x1234 on port 0 in the same cycle lane 1 reads rj=5, with ex_allowin=1 -> ex_rj_data[lane1]=0x1234 next cycle. Writes on ports 0 and 2 to x7 (0xA, 0xB) -> later read returns 0xB.
- Load into x9 accepted; the next bundle has rk0=9 -> stall=1, reg_allowin=0, bubble with ex_valid=0. After mem_adv pulses, the scoreboard drains across LOAD_LAT=2 steps; with no mem_adv, stall holds indefinitely.
- Bundle with rj0=0 while sb holds 0 -> no stall. The bundle is accepted with ex_rj_data=0.
- Hold with ex_allowin=0, fwd_hold=1. fwd_valid_j[0] pulses with 0xDEAD in cycle 1, then 0xBEEF is driven in cycle 3 without a strobe -> ex_rj_data[0]=0xBEEF through the sticky flag. Dropping fwd_hold clears sticky and the operand holds.
- Flush asserted together with mem_adv while a load is in the stage -> all outputs 0 and the scoreboard stays 0. The next bundle is accepted without a stall.
- Reset asserted mid-hold with the scoreboard full -> next cycle all outputs 0, reg_allowin=ex_allowin.
